jtag_mem_arb: RTL and testbench
===============================

JTAG_MEM_ARB -- requirements
Module: jtag_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 64, memory data width.
REQ-003 Parameter LOCK_MAX, default 8, maximum consecutive locked JTAG grants before a forced core grant; legal range 1..255.
REQ-004 Ports, in order:
- TCK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- J_REQ  in  1  JTAG access request.
- J_WE  in  1  JTAG write (1) / read (0).
- J_LOCK  in  1  JTAG burst-lock request.
- J_ADDR  in  ADDR_W  JTAG address.
- J_WDATA  in  DATA_W  JTAG write data.
- J_GNT  out  1  JTAG request accepted this cycle.
- J_RVALID  out  1  JTAG read data valid.
- J_RDATA  out  DATA_W  JTAG read data.
- C_REQ, C_WE, C_ADDR, C_WDATA, C_GNT, C_RVALID, C_RDATA: core-side equivalents with the same directions and widths; there is no C_LOCK.
- EN  out  1  memory enable.
- WREN  out  1  memory write enable.
- ADDR  out  ADDR_W  memory address.
- TO_MEM  out  DATA_W  memory write data.
- FROM_MEM  in  DATA_W  memory read data, valid 1 cycle after EN.
- DBG  out  6  {state[1:0], last_owner, lock_cnt[2:0]}.

Function
REQ-005 J_GNT and C_GNT are combinational from the current REQ inputs and registered state; at most one is high per cycle, and GNT is never high without the matching REQ.
REQ-006 Grant at cycle N drives EN=1, WREN=WE, ADDR and TO_MEM from registers at cycle N+1; with no grant, EN=0 and WREN=0 at N+1, while ADDR and TO_MEM hold.
REQ-007 A read granted at N makes the owner's RVALID=1 at N+2, with RDATA=FROM_MEM in that cycle.
- Writes produce no RVALID.
- The non-owner's RVALID stays 0.
- Back-to-back reads give one RVALID per cycle, in order.
REQ-008 State ARB arbitration:
- A single requester wins.
- When both request, the one that is not last_owner wins.
- last_owner updates on every grant.
REQ-009 ARB -> LOCKED when J is granted with J_LOCK=1; lock_cnt is set to 1.
REQ-010 LOCKED behaviour:
- Only J is granted; C_GNT=0.
- Each J grant increments lock_cnt, saturating at LOCK_MAX.
- J_LOCK=0 in any cycle -> ARB next cycle, and that cycle arbitrates as ARB.
REQ-011 LOCKED with lock_cnt==LOCK_MAX and C_REQ=1 -> FORCE.
REQ-012 FORCE behaviour:
- Grants C only, when C_REQ=1.
- On the C grant, lock_cnt is cleared, then the next state is LOCKED if J_LOCK=1, else ARB.
- If C_REQ drops first, return to LOCKED without clearing lock_cnt.
REQ-013 When J_LOCK deasserts in the same cycle lock_cnt reaches LOCK_MAX, J_LOCK wins and the next state is ARB.
REQ-014 J_LOCK rising while C holds the last grant has no effect until J's next grant.
REQ-015 State encoding: ARB=0, LOCKED=1, FORCE=2; 3 is unreachable and recovers to ARB.

Reset
REQ-016 RESET asserted, at any time, asynchronously forces:
- state=ARB, last_owner=C (J wins the first tie), lock_cnt=0.
- Pipeline valid bits cleared.
- All outputs 0, including ADDR, TO_MEM and DBG.
REQ-017 Reads in flight when RESET asserts never produce RVALID.

Structure
REQ-018 The state encoding, owner encoding (J=0, C=1) and LOCK_MAX default belong in shared package jtag_arb_pkg.
REQ-019 The two-way round-robin grant logic is a sub-module named jtag_rr_arb2, instantiated once.

Verification
REQ-020 Both request reads after reset, addresses J=0x10 and C=0x20:
- Cycle 0: J_GNT. Cycle 1: C_GNT.
- ADDR=0x10 at cycle 1, ADDR=0x20 at cycle 2.
- J_RVALID at cycle 2, C_RVALID at cycle 3, each carrying its own FROM_MEM.
REQ-021 J write of 0xDEADBEEF_CAFEF00D to address 0x40: next cycle EN=1, WREN=1, ADDR=0x40, TO_MEM matches; no RVALID ever.
REQ-022 J_LOCK=1 with J_REQ and C_REQ held high, LOCK_MAX=8:
- 8 J grants, then exactly 1 C grant, then 8 J grants.
- DBG state sequence shows 1, then 2, then 1.
REQ-023 J_LOCK drops at the 8th locked grant with C_REQ=1: next cycle is ARB and C_GNT=1 (C is not last_owner).
REQ-024 RESET pulsed one cycle after a J read grant: J_RVALID is never asserted, all outputs read 0, and the first tied request afterwards grants J.

Source files
------------

// File: rtl/jtag_arb_pkg.sv
// ---------------------------------------------------------------------------
// jtag_arb_pkg
// Shared definitions for the JTAG / core memory arbiter.
//   arbState_t       : arbiter state encoding (ARB=0, LOCKED=1, FORCE=2)
//   OWNER_J, OWNER_C : encoding of the last_owner bit
//   LOCK_MAX_DEFAULT : default limit on consecutive locked JTAG grants
// ---------------------------------------------------------------------------
package jtag_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FORCE  = 2'd2,
        ST_UNUSED = 2'd3
    } arbState_t;

    localparam logic OWNER_J = 1'b0;
    localparam logic OWNER_C = 1'b1;

    localparam int LOCK_MAX_DEFAULT = 8;

endpackage

// File: rtl/jtag_rr_arb2.sv
// ---------------------------------------------------------------------------
// jtag_rr_arb2
// Two-way round-robin grant logic, purely combinational.
//   i_jReq, i_cReq : JTAG / core requests
//   i_lastOwner    : requester granted most recently (OWNER_J / OWNER_C)
//   o_jGnt, o_cGnt : one-hot (or zero) grants
// A lone requester always wins; on a tie the side that is not the last
// owner wins.
// ---------------------------------------------------------------------------
module jtag_rr_arb2
    import jtag_arb_pkg::*;
(
    input  logic i_jReq,
    input  logic i_cReq,
    input  logic i_lastOwner,
    output logic o_jGnt,
    output logic o_cGnt
);

    assign o_jGnt = i_jReq & (~i_cReq | (i_lastOwner == OWNER_C));
    assign o_cGnt = i_cReq & (~i_jReq | (i_lastOwner == OWNER_J));

endmodule

// File: rtl/jtag_mem_arb.sv
// ---------------------------------------------------------------------------
// jtag_mem_arb
// Arbitrates a single memory port between a JTAG master and the core.
//   TCK, RESET            : clock (rising edge), async active-high reset
//   J_* / C_*             : request side for JTAG and core (REQ, WE, ADDR,
//                           WDATA in; GNT, RVALID, RDATA out); JTAG also has
//                           J_LOCK to hold the memory for a burst
//   EN, WREN, ADDR, TO_MEM: registered memory command, one cycle after grant
//   FROM_MEM              : memory read data, valid one cycle after EN
//   DBG                   : {state[1:0], last_owner, lock_cnt[2:0]}
// JTAG may lock the memory for up to LOCK_MAX grants; when the limit is hit
// while the core is waiting, the core gets exactly one forced grant.
// ---------------------------------------------------------------------------
module jtag_mem_arb
    import jtag_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic              TCK,
    input  logic              RESET,
    input  logic              J_REQ,
    input  logic              J_WE,
    input  logic              J_LOCK,
    input  logic [ADDR_W-1:0] J_ADDR,
    input  logic [DATA_W-1:0] J_WDATA,
    output logic              J_GNT,
    output logic              J_RVALID,
    output logic [DATA_W-1:0] J_RDATA,
    input  logic              C_REQ,
    input  logic              C_WE,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    output logic              C_GNT,
    output logic              C_RVALID,
    output logic [DATA_W-1:0] C_RDATA,
    output logic              EN,
    output logic              WREN,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] TO_MEM,
    input  logic [DATA_W-1:0] FROM_MEM,
    output logic [5:0]        DBG
);

    localparam logic [7:0] LOCK_MAX_V = 8'(LOCK_MAX);

    arbState_t         r_state;
    logic              r_lastOwner;
    logic [7:0]        r_lockCnt;
    logic [5:0]        r_dbg;
    logic              r_en;
    logic              r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_toMem;
    logic              r_rdPend;
    logic              r_rdOwner;
    logic              r_jRvalid;
    logic              r_cRvalid;

    logic              w_rrJ;
    logic              w_rrC;
    logic              w_jGnt;
    logic              w_cGnt;
    logic [7:0]        w_cntInc;
    arbState_t         w_stateNxt;
    logic              w_ownerNxt;
    logic [7:0]        w_cntNxt;

    jtag_rr_arb2 u_rr (
        .i_jReq      (J_REQ),
        .i_cReq      (C_REQ),
        .i_lastOwner (r_lastOwner),
        .o_jGnt      (w_rrJ),
        .o_cGnt      (w_rrC)
    );

    // Grants are combinational; only ARB uses the round-robin result.
    // Held at 0 while RESET is asserted so every output reads 0 in reset.
    always_comb begin
        w_jGnt = 1'b0;
        w_cGnt = 1'b0;
        case (r_state)
            ST_ARB: begin
                w_jGnt = w_rrJ;
                w_cGnt = w_rrC;
            end
            ST_LOCKED: w_jGnt = J_REQ;
            ST_FORCE:  w_cGnt = C_REQ;
            default: ;
        endcase
        if (RESET) begin
            w_jGnt = 1'b0;
            w_cGnt = 1'b0;
        end
    end

    assign w_cntInc = (r_lockCnt < LOCK_MAX_V) ? 8'(r_lockCnt + 8'd1) : r_lockCnt;

    // Next-state logic. The FORCE decision looks at the count after this
    // cycle's grant, so the grant that reaches LOCK_MAX is the last JTAG one
    // before the core gets its turn. A dropped J_LOCK takes priority.
    always_comb begin
        w_stateNxt = r_state;
        w_cntNxt   = r_lockCnt;
        w_ownerNxt = r_lastOwner;
        if (w_jGnt) begin
            w_ownerNxt = OWNER_J;
        end else if (w_cGnt) begin
            w_ownerNxt = OWNER_C;
        end
        case (r_state)
            ST_ARB: begin
                if (w_jGnt && J_LOCK) begin
                    w_stateNxt = ST_LOCKED;
                    w_cntNxt   = 8'd1;
                end
            end
            ST_LOCKED: begin
                if (w_jGnt) begin
                    w_cntNxt = w_cntInc;
                end
                if (!J_LOCK) begin
                    w_stateNxt = ST_ARB;
                end else if (C_REQ && (w_cntNxt == LOCK_MAX_V)) begin
                    w_stateNxt = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (C_REQ) begin
                    w_cntNxt   = 8'd0;
                    w_stateNxt = J_LOCK ? ST_LOCKED : ST_ARB;
                end else begin
                    w_stateNxt = ST_LOCKED;
                end
            end
            default: w_stateNxt = ST_ARB;
        endcase
    end

    // Arbiter state. DBG is registered from the next-state values so it
    // mirrors the live state, yet reads 0 while reset holds last_owner at C.
    always_ff @(posedge TCK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_ARB;
            r_lastOwner <= OWNER_C;
            r_lockCnt   <= 8'd0;
            r_dbg       <= 6'd0;
        end else begin
            r_state     <= w_stateNxt;
            r_lastOwner <= w_ownerNxt;
            r_lockCnt   <= w_cntNxt;
            r_dbg       <= {w_stateNxt, w_ownerNxt, w_cntNxt[2:0]};
        end
    end

    // Memory command stage plus the read-return stage. ADDR/TO_MEM hold
    // when there is no grant; r_rdPend/r_rdOwner track the read whose data
    // appears on FROM_MEM one cycle later.
    always_ff @(posedge TCK or posedge RESET) begin
        if (RESET) begin
            r_en      <= 1'b0;
            r_wren    <= 1'b0;
            r_addr    <= '0;
            r_toMem   <= '0;
            r_rdPend  <= 1'b0;
            r_rdOwner <= OWNER_J;
            r_jRvalid <= 1'b0;
            r_cRvalid <= 1'b0;
        end else begin
            r_en      <= w_jGnt | w_cGnt;
            r_wren    <= (w_jGnt & J_WE) | (w_cGnt & C_WE);
            if (w_jGnt) begin
                r_addr  <= J_ADDR;
                r_toMem <= J_WDATA;
            end else if (w_cGnt) begin
                r_addr  <= C_ADDR;
                r_toMem <= C_WDATA;
            end
            r_rdPend  <= (w_jGnt & ~J_WE) | (w_cGnt & ~C_WE);
            r_rdOwner <= w_cGnt ? OWNER_C : OWNER_J;
            r_jRvalid <= r_rdPend & (r_rdOwner == OWNER_J);
            r_cRvalid <= r_rdPend & (r_rdOwner == OWNER_C);
        end
    end

    assign J_GNT    = w_jGnt;
    assign C_GNT    = w_cGnt;
    assign EN       = r_en;
    assign WREN     = r_wren;
    assign ADDR     = r_addr;
    assign TO_MEM   = r_toMem;
    assign J_RVALID = r_jRvalid;
    assign C_RVALID = r_cRvalid;
    assign J_RDATA  = r_jRvalid ? FROM_MEM : '0;
    assign C_RDATA  = r_cRvalid ? FROM_MEM : '0;
    assign DBG      = r_dbg;

endmodule

// File: tb/tb_jtag_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_jtag_mem_arb
// Self-checking bench for jtag_mem_arb with default parameters.
// A simple memory model returns {32'h12345678, address} one cycle after EN.
// ---------------------------------------------------------------------------
module tb_jtag_mem_arb;

    logic        TCK;
    logic        RESET;
    logic        J_REQ, J_WE, J_LOCK;
    logic [31:0] J_ADDR;
    logic [63:0] J_WDATA;
    logic        J_GNT, J_RVALID;
    logic [63:0] J_RDATA;
    logic        C_REQ, C_WE;
    logic [31:0] C_ADDR;
    logic [63:0] C_WDATA;
    logic        C_GNT, C_RVALID;
    logic [63:0] C_RDATA;
    logic        EN, WREN;
    logic [31:0] ADDR;
    logic [63:0] TO_MEM;
    logic [63:0] FROM_MEM;
    logic [5:0]  DBG;

    int errors;
    int checks;

    typedef struct {
        logic        jReq;
        logic        jWe;
        logic        jLock;
        logic [31:0] jAddr;
        logic [63:0] jWdata;
        logic        cReq;
        logic        cWe;
        logic [31:0] cAddr;
        logic        eJGnt;
        logic        eCGnt;
        logic        eEn;
        logic        eWren;
        logic [31:0] eAddr;
        logic [63:0] eToMem;
        logic        ckToMem;
        logic        eJRv;
        logic        eCRv;
        logic [63:0] eRdata;
        logic [1:0]  eState;
    } vec_t;

    vec_t vecs [12];

    jtag_mem_arb dut (
        .TCK      (TCK),
        .RESET    (RESET),
        .J_REQ    (J_REQ),
        .J_WE     (J_WE),
        .J_LOCK   (J_LOCK),
        .J_ADDR   (J_ADDR),
        .J_WDATA  (J_WDATA),
        .J_GNT    (J_GNT),
        .J_RVALID (J_RVALID),
        .J_RDATA  (J_RDATA),
        .C_REQ    (C_REQ),
        .C_WE     (C_WE),
        .C_ADDR   (C_ADDR),
        .C_WDATA  (C_WDATA),
        .C_GNT    (C_GNT),
        .C_RVALID (C_RVALID),
        .C_RDATA  (C_RDATA),
        .EN       (EN),
        .WREN     (WREN),
        .ADDR     (ADDR),
        .TO_MEM   (TO_MEM),
        .FROM_MEM (FROM_MEM),
        .DBG      (DBG)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    // Memory model: data for the address presented with EN appears next cycle.
    initial FROM_MEM = 64'h0;
    always @(posedge TCK) begin
        if (EN) FROM_MEM <= {32'h12345678, ADDR};
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expVal);
        checks++;
        if (act !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expVal);
        end
    endtask

    task automatic setInputs(input logic jReq, input logic jWe, input logic jLock,
                             input logic [31:0] jAddr, input logic [63:0] jWdata,
                             input logic cReq, input logic cWe, input logic [31:0] cAddr);
        J_REQ   = jReq;
        J_WE    = jWe;
        J_LOCK  = jLock;
        J_ADDR  = jAddr;
        J_WDATA = jWdata;
        C_REQ   = cReq;
        C_WE    = cWe;
        C_ADDR  = cAddr;
        C_WDATA = 64'h0;
    endtask

    task automatic applyStimulus(input vec_t v);
        setInputs(v.jReq, v.jWe, v.jLock, v.jAddr, v.jWdata, v.cReq, v.cWe, v.cAddr);
    endtask

    task automatic nextCycle();
        @(posedge TCK);
        #1;
    endtask

    task automatic idle();
        setInputs(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Leaves the bench one time unit after a rising edge with reset released.
    task automatic doReset();
        idle();
        RESET = 1'b1;
        @(posedge TCK);
        @(posedge TCK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " EN"},       {63'h0, EN},       64'h0);
        checkOutput({tag, " WREN"},     {63'h0, WREN},     64'h0);
        checkOutput({tag, " ADDR"},     {32'h0, ADDR},     64'h0);
        checkOutput({tag, " TO_MEM"},   TO_MEM,            64'h0);
        checkOutput({tag, " DBG"},      {58'h0, DBG},      64'h0);
        checkOutput({tag, " J_GNT"},    {63'h0, J_GNT},    64'h0);
        checkOutput({tag, " C_GNT"},    {63'h0, C_GNT},    64'h0);
        checkOutput({tag, " J_RVALID"}, {63'h0, J_RVALID}, 64'h0);
        checkOutput({tag, " C_RVALID"}, {63'h0, C_RVALID}, 64'h0);
        checkOutput({tag, " J_RDATA"},  J_RDATA,           64'h0);
        checkOutput({tag, " C_RDATA"},  C_RDATA,           64'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        RESET = 1'b1;

        // Fields: jReq jWe jLock jAddr jWdata | cReq cWe cAddr |
        //         eJGnt eCGnt eEn eWren eAddr eToMem ckToMem eJRv eCRv eRdata eState
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h10, 64'h0, 1'b1, 1'b0, 32'h20,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h10, 64'h0, 1'b1, 1'b0, 32'h20,
                     1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 64'h0, 1'b0, 1'b1, 1'b0, 64'h12345678_00000010, 2'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 64'h0, 1'b0, 1'b0, 1'b1, 64'h12345678_00000020, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h50, 64'h0, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h58, 64'h0, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h60,
                     1'b0, 1'b1, 1'b1, 1'b0, 32'h58, 64'h0, 1'b0, 1'b1, 1'b0, 64'h12345678_00000050, 2'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b1, 1'b0, 32'h60, 64'h0, 1'b0, 1'b1, 1'b0, 64'h12345678_00000058, 2'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h60, 64'h0, 1'b0, 1'b0, 1'b1, 64'h12345678_00000060, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h60, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 2'd0};

        // Outputs while reset is held from time zero.
        #2;
        checkAllZero("reset");

        // Table: tie after reset, read ordering, write, back-to-back reads.
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("c%0d J_GNT", i),    {63'h0, J_GNT},    {63'h0, vecs[i].eJGnt});
            checkOutput($sformatf("c%0d C_GNT", i),    {63'h0, C_GNT},    {63'h0, vecs[i].eCGnt});
            checkOutput($sformatf("c%0d EN", i),       {63'h0, EN},       {63'h0, vecs[i].eEn});
            checkOutput($sformatf("c%0d WREN", i),     {63'h0, WREN},     {63'h0, vecs[i].eWren});
            checkOutput($sformatf("c%0d ADDR", i),     {32'h0, ADDR},     {32'h0, vecs[i].eAddr});
            checkOutput($sformatf("c%0d J_RVALID", i), {63'h0, J_RVALID}, {63'h0, vecs[i].eJRv});
            checkOutput($sformatf("c%0d C_RVALID", i), {63'h0, C_RVALID}, {63'h0, vecs[i].eCRv});
            checkOutput($sformatf("c%0d state", i),    {62'h0, DBG[5:4]}, {62'h0, vecs[i].eState});
            if (vecs[i].ckToMem) checkOutput($sformatf("c%0d TO_MEM", i), TO_MEM, vecs[i].eToMem);
            if (vecs[i].eJRv)    checkOutput($sformatf("c%0d J_RDATA", i), J_RDATA, vecs[i].eRdata);
            if (vecs[i].eCRv)    checkOutput($sformatf("c%0d C_RDATA", i), C_RDATA, vecs[i].eRdata);
            nextCycle();
        end

        // Locked burst with both sides requesting: 8 J, 1 C, 8 J, 1 C.
        doReset();
        for (int i = 0; i < 18; i++) begin
            logic expJ;
            logic expC;
            logic [1:0] expSt;
            expJ  = (i < 8) || (i >= 9 && i <= 16);
            expC  = (i == 8) || (i == 17);
            expSt = (i == 0) ? 2'd0 : (expC ? 2'd2 : 2'd1);
            setInputs(1'b1, 1'b0, 1'b1, 32'h100, 64'h0, 1'b1, 1'b0, 32'h200);
            #2;
            checkOutput($sformatf("lock%0d J_GNT", i), {63'h0, J_GNT},    {63'h0, expJ});
            checkOutput($sformatf("lock%0d C_GNT", i), {63'h0, C_GNT},    {63'h0, expC});
            checkOutput($sformatf("lock%0d state", i), {62'h0, DBG[5:4]}, {62'h0, expSt});
            nextCycle();
        end

        // J_LOCK drops on the 8th locked grant: J_LOCK wins, then C wins the tie.
        doReset();
        for (int i = 0; i < 9; i++) begin
            logic expJ;
            logic [1:0] expSt;
            expJ  = (i < 8);
            expSt = (i == 0 || i == 8) ? 2'd0 : 2'd1;
            setInputs(1'b1, 1'b0, (i < 7), 32'h100, 64'h0, 1'b1, 1'b0, 32'h200);
            #2;
            checkOutput($sformatf("drop%0d J_GNT", i), {63'h0, J_GNT},    {63'h0, expJ});
            checkOutput($sformatf("drop%0d C_GNT", i), {63'h0, C_GNT},    {63'h0, !expJ});
            checkOutput($sformatf("drop%0d state", i), {62'h0, DBG[5:4]}, {62'h0, expSt});
            nextCycle();
        end

        // Reset pulse one cycle after a J read grant kills the read.
        doReset();
        setInputs(1'b1, 1'b0, 1'b0, 32'h30, 64'h0, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("rst J_GNT", {63'h0, J_GNT}, 64'h1);
        nextCycle();
        idle();
        RESET = 1'b1;
        #2;
        checkAllZero("rstpulse");
        nextCycle();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput($sformatf("rst%0d J_RVALID", i), {63'h0, J_RVALID}, 64'h0);
            nextCycle();
        end
        setInputs(1'b1, 1'b0, 1'b0, 32'h34, 64'h0, 1'b1, 1'b0, 32'h38);
        #2;
        checkOutput("post-rst tie J_GNT", {63'h0, J_GNT}, 64'h1);
        checkOutput("post-rst tie C_GNT", {63'h0, C_GNT}, 64'h0);
        nextCycle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
